// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and geometry defaults for the instruction cache
//
// Contents:
//   state_t      controller states (idle / line fill / fill response)
//   INDEX_W_DEF  default set-index width (64 sets)
//   OFF_W_DEF    default word-offset width (4 words per line)
//   tag_width()  tag bits left over from a 32-bit byte address
package icache_pkg;

    localparam int INDEX_W_DEF = 6;
    localparam int OFF_W_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int tag_width(input int index_w, input int off_w);
        return 32 - index_w - off_w - 2;
    endfunction

    localparam int TAG_W_DEF = tag_width(INDEX_W_DEF, OFF_W_DEF);

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for the direct-mapped instruction cache
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset clears every valid bit
//   rd_index/offset  combinational lookup address
//   rd_tag           tag to compare against the stored tag of rd_index
//   rd_hit, rd_word  lookup result (word is meaningless when rd_hit is low)
//   wr_en            write wr_data into word {wr_index, wr_offset}
//   install          mark wr_index valid and store wr_tag
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int OFF_W   = OFF_W_DEF,
    parameter int TAG_W   = 32 - INDEX_W - OFF_W - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [OFF_W-1:0]   rd_offset,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [31:0]        rd_word,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [OFF_W-1:0]   wr_offset,
    input  logic [31:0]        wr_data,
    input  logic               install,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = 1 << OFF_W;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*WORDS];

    // Only the valid bits are reset; stale tags/data are harmless behind them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
        if (install) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_word = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache between the fetch unit and the memory controller
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   rdy                   global enable, low freezes all state
//   IF_pc_sgn, IF_pc      fetch request and its byte address
//   IF_ins_sgn, IF_ins    one-cycle instruction-valid pulse and instruction
//   clr                   fetch redirect, cancels the outstanding response
//   MC_req, MC_addr       line-fill request (level) and line base address
//   MC_valid, MC_data     fill beat strobe and word, ascending offsets from 0
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int OFF_W   = OFF_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    input  logic        clr,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_valid,
    input  logic [31:0] MC_data
);

    localparam int TAG_W = tag_width(INDEX_W, OFF_W);
    localparam int LSB   = OFF_W + 2;

    state_t             state;
    logic [31:2]        pc_q;
    logic [OFF_W-1:0]   cnt;
    logic               drop;
    logic               ins_sgn_q;
    logic [31:0]        ins_q;
    logic               mc_req_q;
    logic [31:0]        mc_addr_q;

    logic [INDEX_W-1:0] req_index;
    logic [OFF_W-1:0]   req_off;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_index;
    logic [OFF_W-1:0]   fill_off;
    logic [TAG_W-1:0]   fill_tag;
    logic               rd_hit;
    logic [31:0]        rd_word;
    logic               beat;
    logic               last_beat;

    // Byte-within-word bits carry no information for an instruction fetch.
    wire unused_pc_bits = ^IF_pc[1:0];

    // Lookup runs on the live request so a hit can answer on the next cycle.
    assign req_off    = IF_pc[LSB-1:2];
    assign req_index  = IF_pc[INDEX_W+LSB-1:LSB];
    assign req_tag    = IF_pc[31:INDEX_W+LSB];

    // Fill addressing comes from the latched miss address.
    assign fill_off   = pc_q[LSB-1:2];
    assign fill_index = pc_q[INDEX_W+LSB-1:LSB];
    assign fill_tag   = pc_q[31:INDEX_W+LSB];

    // A beat only counts while enabled; stray strobes with rdy low are dropped.
    assign beat      = rdy && (state == ST_FILL) && MC_valid;
    assign last_beat = beat && (cnt == {OFF_W{1'b1}});

    icache_array #(
        .INDEX_W (INDEX_W),
        .OFF_W   (OFF_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (req_index),
        .rd_offset (req_off),
        .rd_tag    (req_tag),
        .rd_hit    (rd_hit),
        .rd_word   (rd_word),
        .wr_en     (beat),
        .wr_index  (fill_index),
        .wr_offset (cnt),
        .wr_data   (MC_data),
        .install   (last_beat),
        .wr_tag    (fill_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc_q      <= '0;
            cnt       <= '0;
            drop      <= 1'b0;
            ins_sgn_q <= 1'b0;
            ins_q     <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    ins_sgn_q <= 1'b0;
                    if (IF_pc_sgn) begin
                        pc_q <= IF_pc[31:2];
                        if (rd_hit) begin
                            ins_sgn_q <= 1'b1;
                            ins_q     <= rd_word;
                        end else begin
                            state     <= ST_FILL;
                            mc_req_q  <= 1'b1;
                            mc_addr_q <= {IF_pc[31:LSB], {LSB{1'b0}}};
                            cnt       <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    if (clr) begin
                        drop <= 1'b1;
                    end
                    if (MC_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == fill_off) begin
                            ins_q <= MC_data;
                        end
                        if (cnt == {OFF_W{1'b1}}) begin
                            mc_req_q  <= 1'b0;
                            state     <= ST_RESP;
                            // A redirect on the final beat itself also kills the response.
                            ins_sgn_q <= !(drop || clr);
                        end
                    end
                end
                ST_RESP: begin
                    ins_sgn_q <= 1'b0;
                    drop      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The redirect is the only combinational path to an output.
    assign IF_ins_sgn = ins_sgn_q && !clr;
    assign IF_ins     = ins_q;
    assign MC_req     = mc_req_q;
    assign MC_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard testbench for icache against a set/tag reference model
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        IF_pc_sgn = 1'b0;
    logic [31:0] IF_pc = '0;
    logic        clr = 1'b0;
    logic        MC_valid = 1'b0;
    logic [31:0] MC_data = '0;
    wire         IF_ins_sgn;
    wire  [31:0] IF_ins;
    wire         MC_req;
    wire  [31:0] MC_addr;

    always #5 clk = ~clk;

    icache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .IF_pc_sgn  (IF_pc_sgn),
        .IF_pc      (IF_pc),
        .IF_ins_sgn (IF_ins_sgn),
        .IF_ins     (IF_ins),
        .clr        (clr),
        .MC_req     (MC_req),
        .MC_addr    (MC_addr),
        .MC_valid   (MC_valid),
        .MC_data    (MC_data)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [logic [31:0]];
    bit          model_valid [64];
    logic [21:0] model_tag [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: any word not yet seen gets a random value, fixed from then on.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return model_valid[pc[9:4]] && (model_tag[pc[9:4]] == pc[31:10]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every instruction pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && IF_ins_sgn) begin
            if (exp_q.size() == 0) check("spurious_resp", {31'b0, IF_ins_sgn}, 32'h0);
            else check("resp_data", IF_ins, exp_q.pop_front());
        end
    end

    // One fetch; for a miss the bench plays memory controller.
    // clr_beat: redirect in an idle cycle before that beat; rdy_beat: rdy low 3 cycles
    // (with junk strobes) before that beat; max_gap: random idle cycles between beats.
    task automatic fetch(input logic [31:0] pc, input int clr_beat, input int rdy_beat, input int max_gap);
        logic [31:0] base;
        logic [31:0] word_addr;
        bit          dropped;
        int          gap;
        base      = {pc[31:4], 4'b0};
        word_addr = {pc[31:2], 2'b0};
        dropped   = 1'b0;
        IF_pc     = pc;
        IF_pc_sgn = 1'b1;
        if (model_hit(pc)) begin
            tick();
            IF_pc_sgn = 1'b0;
            exp_q.push_back(word_at(word_addr));
        end else begin
            tick();
            IF_pc_sgn = 1'b0;
            check("miss_req", {31'b0, MC_req}, 32'h1);
            check("miss_addr", MC_addr, base);
            for (int b = 0; b < 4; b++) begin
                gap = $urandom_range(max_gap, 0);
                for (int g = 0; g < gap; g++) begin
                    // Requests during a fill must be ignored.
                    IF_pc_sgn = $urandom_range(1, 0);
                    IF_pc     = $urandom;
                    tick();
                    IF_pc_sgn = 1'b0;
                    check("addr_stable", MC_addr, base);
                end
                if (b == clr_beat) begin
                    clr     = 1'b1;
                    dropped = 1'b1;
                    tick();
                    clr = 1'b0;
                end
                if (b == rdy_beat) begin
                    rdy      = 1'b0;
                    MC_valid = 1'b1;
                    MC_data  = ~word_at(base + 32'(4 * b));
                    repeat (3) tick();
                    check("addr_hold_rdy", MC_addr, base);
                    check("req_hold_rdy", {31'b0, MC_req}, 32'h1);
                    MC_valid = 1'b0;
                    rdy      = 1'b1;
                end
                MC_valid = 1'b1;
                MC_data  = word_at(base + 32'(4 * b));
                tick();
                MC_valid = 1'b0;
            end
            check("req_drop", {31'b0, MC_req}, 32'h0);
            model_valid[pc[9:4]] = 1'b1;
            model_tag[pc[9:4]]   = pc[31:10];
            if (!dropped) exp_q.push_back(word_at(word_addr));
            tick();
        end
    endtask

    // Hit on pc1, then redirect with a new request pc2 in the response cycle.
    task automatic clr_redirect(input logic [31:0] pc1, input logic [31:0] pc2);
        IF_pc     = pc1;
        IF_pc_sgn = 1'b1;
        tick();
        IF_pc = pc2;
        clr   = 1'b1;
        tick();
        clr       = 1'b0;
        IF_pc_sgn = 1'b0;
        exp_q.push_back(word_at({pc2[31:2], 2'b0}));
    endtask

    task automatic reset_mid_fill(input logic [31:0] pc);
        logic [31:0] base;
        base      = {pc[31:4], 4'b0};
        IF_pc     = pc;
        IF_pc_sgn = 1'b1;
        tick();
        IF_pc_sgn = 1'b0;
        check("rst_fill_req", {31'b0, MC_req}, 32'h1);
        for (int b = 0; b < 2; b++) begin
            MC_valid = 1'b1;
            MC_data  = word_at(base + 32'(4 * b));
            tick();
            MC_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_async", {31'b0, MC_req}, 32'h0);
        check("rst_addr_async", MC_addr, 32'h0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] pc;
        model_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        repeat (2) tick();
        check("rst_ins_sgn", {31'b0, IF_ins_sgn}, 32'h0);
        check("rst_ins", IF_ins, 32'h0);
        check("rst_req", {31'b0, MC_req}, 32'h0);
        check("rst_addr", MC_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        mem[32'h1000] = 32'hA0;
        mem[32'h1004] = 32'hA1;
        mem[32'h1008] = 32'hA2;
        mem[32'h100C] = 32'hA3;
        fetch(32'h0000_1004, -1, -1, 0);
        for (int k = 0; k < 4; k++) fetch(32'h1000 + 32'(4 * k), -1, -1, 0);

        fetch(32'h0000_2000, -1, -1, 0);
        fetch(32'h0000_1000, -1, -1, 0);

        fetch(32'h0000_3008, 2, -1, 0);
        fetch(32'h0000_3008, -1, -1, 0);

        fetch(32'h0000_4010, -1, 1, 3);
        for (int k = 0; k < 4; k++) fetch(32'h4010 + 32'(4 * k), -1, -1, 0);

        clr_redirect(32'h0000_3008, 32'h0000_4014);

        reset_mid_fill(32'h0000_5020);
        fetch(32'h0000_5020, -1, -1, 1);
        fetch(32'h0000_3008, -1, -1, 0);

        for (int n = 0; n < 250; n++) begin
            pc = 32'h0001_0000
               | (32'($urandom_range(3, 0)) << 10)
               | (32'($urandom_range(7, 0)) << 4)
               | (32'($urandom_range(3, 0)) << 2)
               | 32'($urandom_range(3, 0));
            fetch(pc,
                  ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                  ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                  2);
            if ($urandom_range(3, 0) == 0) tick();
        end

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
